// File: rtl/stream_demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer.
//   NUM_CH    : number of output channels
//   SEL_W     : width of a channel index (in_dest, rr_ptr)
//   MODE_DEST : route by in_dest
//   MODE_RR   : route by the round-robin pointer
package stream_demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  localparam logic MODE_DEST = 1'b0;
  localparam logic MODE_RR   = 1'b1;

endpackage

// File: rtl/stream_slot.sv
// One-entry valid/ready holding slot for a single output channel.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : parent accepted a word for this channel this cycle
//   load_data  : word to capture on load
//   ready      : downstream consumer takes the held word this cycle
//   data       : held word (keeps the last loaded value when empty)
//   valid      : slot is full
module stream_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // A load wins over a drain, so a same-cycle take-and-refill leaves no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1x4.sv
// Registered, handshaked 1-to-4 stream demultiplexer.
// Ports:
//   clk, rst_n          : clock and asynchronous active-low reset
//   in_data/in_valid    : input word and its valid flag
//   in_dest             : destination channel when mode = MODE_DEST
//   in_ready            : combinational; target slot is empty or draining
//   mode                : MODE_DEST (in_dest) or MODE_RR (round-robin)
//   y_data              : channel k at bits [k*WIDTH +: WIDTH]
//   y_valid/y_ready     : per-channel handshake
//   rr_ptr              : round-robin pointer, advances on each RR accept
module stream_demux_1x4
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_dest,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
  output logic [NUM_CH*WIDTH-1:0] y_data,
  output logic [NUM_CH-1:0]       y_valid,
  input  logic [NUM_CH-1:0]       y_ready,
  output logic [SEL_W-1:0]        rr_ptr
);

  logic [SEL_W-1:0]  target_c;
  logic              accept_c;
  logic [NUM_CH-1:0] load_c;

  // Target decode and accept; in_ready deliberately ignores in_valid.
  always_comb begin
    target_c = (mode == MODE_RR) ? rr_ptr : in_dest;
    in_ready = !y_valid[target_c] || y_ready[target_c];
    accept_c = in_valid && in_ready;
    load_c   = '0;
    if (accept_c) begin
      load_c[target_c] = 1'b1;
    end
  end

  // Round-robin pointer; wraps naturally at SEL_W bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept_c && (mode == MODE_RR)) begin
      rr_ptr <= SEL_W'(rr_ptr + SEL_W'(1));
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    stream_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_c[k]),
      .load_data (in_data),
      .ready     (y_ready[k]),
      .data      (y_data[k*WIDTH +: WIDTH]),
      .valid     (y_valid[k])
    );
  end

endmodule

// File: tb/tb_stream_demux_1x4.sv
// Directed, table-driven bench for stream_demux_1x4.
module tb_stream_demux_1x4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [1:0]  in_dest;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [31:0] y_data;
  logic [3:0]  y_valid;
  logic [3:0]  y_ready;
  logic [1:0]  rr_ptr;

  int checks = 0;
  int errors = 0;

  stream_demux_1x4 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .y_data   (y_data),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .rr_ptr   (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [1:0]  dest;
    logic [7:0]  data;
    logic        valid;
    logic [3:0]  yr;
    logic        exp_rdy;
    logic [3:0]  exp_yv;
    logic [31:0] exp_yd;
    logic [1:0]  exp_rr;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, check in_ready, then check state after the edge.
  task automatic drive(input logic m, input logic [1:0] d, input logic [7:0] dat,
                       input logic v, input logic [3:0] yr);
    @(negedge clk);
    mode     = m;
    in_dest  = d;
    in_data  = dat;
    in_valid = v;
    y_ready  = yr;
    #1;
  endtask

  initial begin
    //          mode  dest   data   vld   yready rdy   yvalid   ydata          rr
    vecs[0]  = '{1'b0, 2'd2, 8'hA1, 1'b1, 4'hF, 1'b1, 4'b0100, 32'h00A1_0000, 2'd0};
    vecs[1]  = '{1'b0, 2'd0, 8'hB2, 1'b1, 4'hF, 1'b1, 4'b0001, 32'h00A1_00B2, 2'd0};
    vecs[2]  = '{1'b1, 2'd0, 8'h10, 1'b1, 4'hF, 1'b1, 4'b0001, 32'h00A1_0010, 2'd1};
    vecs[3]  = '{1'b1, 2'd0, 8'h11, 1'b1, 4'hF, 1'b1, 4'b0010, 32'h00A1_1110, 2'd2};
    vecs[4]  = '{1'b1, 2'd0, 8'h12, 1'b1, 4'hF, 1'b1, 4'b0100, 32'h0012_1110, 2'd3};
    vecs[5]  = '{1'b1, 2'd0, 8'h13, 1'b1, 4'hF, 1'b1, 4'b1000, 32'h1312_1110, 2'd0};
    vecs[6]  = '{1'b1, 2'd0, 8'h14, 1'b1, 4'hF, 1'b1, 4'b0001, 32'h1312_1114, 2'd1};
    vecs[7]  = '{1'b1, 2'd0, 8'h15, 1'b1, 4'hF, 1'b1, 4'b0010, 32'h1312_1514, 2'd2};
    vecs[8]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 32'h1312_1514, 2'd2};
    vecs[9]  = '{1'b0, 2'd1, 8'h55, 1'b1, 4'hD, 1'b1, 4'b0010, 32'h1312_5514, 2'd2};
    vecs[10] = '{1'b0, 2'd1, 8'h66, 1'b1, 4'hD, 1'b0, 4'b0010, 32'h1312_5514, 2'd2};
    vecs[11] = '{1'b0, 2'd3, 8'h77, 1'b1, 4'hD, 1'b1, 4'b1010, 32'h7712_5514, 2'd2};
    vecs[12] = '{1'b0, 2'd1, 8'h66, 1'b1, 4'hF, 1'b1, 4'b0010, 32'h7712_6614, 2'd2};
    vecs[13] = '{1'b1, 2'd0, 8'h20, 1'b1, 4'hF, 1'b1, 4'b0100, 32'h7720_6614, 2'd3};
    vecs[14] = '{1'b0, 2'd0, 8'h21, 1'b1, 4'hF, 1'b1, 4'b0001, 32'h7720_6621, 2'd3};
    vecs[15] = '{1'b0, 2'd1, 8'h22, 1'b1, 4'hF, 1'b1, 4'b0010, 32'h7720_2221, 2'd3};
    vecs[16] = '{1'b1, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 32'h7720_2221, 2'd3};
    vecs[17] = '{1'b1, 2'd0, 8'h23, 1'b1, 4'hF, 1'b1, 4'b1000, 32'h2320_2221, 2'd0};
    vecs[18] = '{1'b1, 2'd0, 8'h00, 1'b0, 4'h0, 1'b1, 4'b1000, 32'h2320_2221, 2'd0};
    vecs[19] = '{1'b0, 2'd3, 8'h00, 1'b0, 4'h0, 1'b0, 4'b1000, 32'h2320_2221, 2'd0};
    vecs[20] = '{1'b0, 2'd3, 8'h99, 1'b1, 4'h0, 1'b0, 4'b1000, 32'h2320_2221, 2'd0};

    rst_n    = 1'b0;
    mode     = 1'b0;
    in_dest  = 2'd0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    y_ready  = 4'b0000;

    // Reset state
    #12;
    chk("reset_y_valid",  0, 32'(y_valid),  32'h0);
    chk("reset_y_data",   0, y_data,        32'h0);
    chk("reset_rr_ptr",   0, 32'(rr_ptr),   32'h0);
    chk("reset_in_ready", 0, 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].mode, vecs[i].dest, vecs[i].data, vecs[i].valid, vecs[i].yr);
      chk("in_ready", i, 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      chk("y_valid", i, 32'(y_valid), 32'(vecs[i].exp_yv));
      chk("y_data",  i, y_data,       vecs[i].exp_yd);
      chk("rr_ptr",  i, 32'(rr_ptr),  32'(vecs[i].exp_rr));
    end

    // Fill all four slots with rr_ptr ending at 3, consumers stalled
    drive(1'b1, 2'd0, 8'hC0, 1'b1, 4'h0);   // ch0 stalled but full (0x23 went to ch3)
    @(posedge clk); #1;
    drive(1'b1, 2'd0, 8'hC1, 1'b1, 4'h0);
    @(posedge clk); #1;
    drive(1'b1, 2'd0, 8'hC2, 1'b1, 4'h0);
    @(posedge clk); #1;
    chk("fill_rr_ptr", 100, 32'(rr_ptr), 32'h3);
    chk("fill_y_valid", 100, 32'(y_valid), 32'hF);
    chk("fill_y_data", 100, y_data, 32'h23C2_C1C0);
    drive(1'b1, 2'd0, 8'hC3, 1'b1, 4'h0);
    chk("full_in_ready", 101, 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    chk("full_hold_rr_ptr", 101, 32'(rr_ptr), 32'h3);
    chk("full_hold_y_data", 101, y_data, 32'h23C2_C1C0);

    // Asynchronous reset mid-operation, observed before the next rising edge
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("async_rst_y_valid", 102, 32'(y_valid), 32'h0);
    chk("async_rst_rr_ptr",  102, 32'(rr_ptr),  32'h0);
    chk("async_rst_y_data",  102, y_data,       32'h0);
    chk("async_rst_in_ready", 102, 32'(in_ready), 32'h1);
    // Held in reset across an edge with traffic offered: nothing loads
    in_valid = 1'b1;
    in_data  = 8'hEE;
    @(posedge clk); #1;
    chk("in_rst_y_valid", 103, 32'(y_valid), 32'h0);
    chk("in_rst_rr_ptr",  103, 32'(rr_ptr),  32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Back-to-back to one channel with the consumer always ready: no bubble
    drive(1'b0, 2'd2, 8'h31, 1'b1, 4'hF);
    @(posedge clk); #1;
    drive(1'b0, 2'd2, 8'h32, 1'b1, 4'hF);
    chk("b2b_in_ready", 104, 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("b2b_y_valid", 104, 32'(y_valid), 32'h4);
    chk("b2b_y_data",  104, y_data,       32'h0032_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #20000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_demux_1x4.md
# stream_demux_1x4

Registered, handshaked 1-to-4 stream demultiplexer. It routes each accepted input word to one of four output channels, chosen either by an explicit destination field or by an internal round-robin pointer. Each channel has a one-entry holding slot, so a stalled channel does not lose data and does not block traffic to the other channels. It sits downstream of the stream source and upstream of per-channel consumers, as the sequential counterpart of the combinational 1x2/1x4 demux stages.

## Interface
- WIDTH, 8, data word width in bits
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  input word
- in_dest  input  2  destination channel; used when mode = 0
- in_valid  input  1  input word present
- in_ready  output  1  block can accept this cycle
- mode  input  1  0 = explicit destination (in_dest), 1 = round-robin
- y_data  output  4*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- y_valid  output  4  slot k holds a word
- y_ready  input  4  consumer k takes the word this cycle
- rr_ptr  output  2  current round-robin pointer, for status and debug

## Operation
- Target channel t = in_dest when mode = 0, and t = rr_ptr when mode = 1.
- Transfer out on channel k when y_valid[k] && y_ready[k].
- in_ready = !y_valid[t] || y_ready[t]. This is combinational on mode, in_dest, rr_ptr, y_valid and y_ready. It does not depend on in_valid.
- Accept when in_valid && in_ready: the next cycle, y_data[t] = in_data and y_valid[t] = 1.
- Channel k not targeted by an accept:
  - if it transfers out, y_valid[k] clears;
  - otherwise its slot holds its value.
- Simultaneous transfer out and accept on the same channel: y_valid stays 1 and the slot loads the new word. There is no bubble, so throughput is one word per cycle.
- rr_ptr:
  - increments modulo 4 (3 → 0) only on an accept while mode = 1;
  - holds while mode = 0;
  - a mode change has no other side effect.
- When in_valid = 1 and in_ready = 0, the input is not consumed and no state changes. The source must hold its word.
- y_data of an empty slot keeps the last word loaded. It reads 0 after reset.
- Contents of each slot: at most one state, either empty or full.

## Timing
- Reset, asynchronous:
  - y_valid = 4'b0000
  - y_data = 0
  - rr_ptr = 0
  - in_ready then evaluates to 1.
- Reset asserted mid-operation discards all held words immediately. No output transfer occurs while rst_n = 0.
- Latency from accept at edge N to y_valid[t] = 1 is 1 cycle, visible after edge N.
- All state updates on the rising edge of clk. The only combinational output is in_ready.
- Consumers must not make y_ready depend on in_ready, so no combinational loop forms.

## Structure
- Package stream_demux_pkg:
  - NUM_CH = 4
  - SEL_W = 2
  - mode constants MODE_DEST = 1'b0 and MODE_RR = 1'b1
- Sub-module stream_slot (one-entry valid/ready register slice, WIDTH parameter), instantiated four times. The top level holds only target decode, in_ready mux and the rr_ptr counter.

## Test plan
- Reset with y_ready = 4'b0000 → y_valid = 0, y_data = 0, rr_ptr = 0, in_ready = 1.
- mode = 0, send 0xA1/dest 2, then 0xB2/dest 0, with all y_ready = 1:
  - y_valid = 4'b0100 with y_data[23:16] = 0xA1;
  - next cycle y_valid = 4'b0001 with y_data[7:0] = 0xB2.
- mode = 1, six accepted words 0x10..0x15 with all y_ready = 1:
  - channels receive them in order 0, 1, 2, 3, 0, 1;
  - rr_ptr = 2 at the end.
- mode = 0, y_ready[1] = 0:
  - send 0x55 to dest 1, then 0x66 to dest 1 → in_ready = 0 and 0x55 holds;
  - meanwhile 0x77 to dest 3 is accepted;
  - raise y_ready[1] → 0x66 is accepted in that same cycle with no bubble.
- Assert rst_n = 0 while all four slots are full → y_valid = 0 and rr_ptr = 0 immediately, before the next edge.
- Toggle mode from 1 to 0 with rr_ptr = 3, send two words, then return to mode 1 → rr_ptr is still 3, and the next round-robin word goes to channel 3.
